// File: rtl/kbd_port_fifo.sv
// kbd_port_fifo: buffered PS/2 keyboard port for the KR580 I/O bus.
// Folds F0 break prefixes into the code byte and queues key events in a
// first-word-fall-through FIFO. The CPU reads the FIFO through four I/O ports:
//   BASE+0 head/pop, BASE+1 status/control, BASE+2 event count, BASE+3 flags.

module kbd_port_fifo #(
    parameter logic [7:0]  BASE       = 8'hFC,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] ps2_data,
    input  logic       ps2_stb,
    input  logic [7:0] ps2_code,
    input  logic [7:0] pin_pa,
    input  logic [7:0] pin_po,
    input  logic       pin_pw,
    input  logic       pin_pr,
    output logic [7:0] pin_pi,
    output logic       pin_sel,
    output logic       pin_intr
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned PtrW  = DEPTH_LOG2;
    localparam int unsigned CntW  = DEPTH_LOG2 + 1;

    localparam logic [1:0] OffData   = 2'd0;
    localparam logic [1:0] OffStatus = 2'd1;
    localparam logic [1:0] OffEvcnt  = 2'd2;
    localparam logic [1:0] OffFlags  = 2'd3;

    localparam logic [7:0] BreakPrefix = 8'hF0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]      mem_q [Depth];
    logic [7:0]      mem_d [Depth];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            brk_q, brk_d;
    logic            ovf_q, ovf_d;
    logic            ien_q, ien_d;
    logic [7:0]      evcnt_q, evcnt_d;
    logic            intr_q, intr_d;

    // ------------------------------------------------------------------
    // Decode and request qualification
    // ------------------------------------------------------------------
    logic [1:0] offset;
    logic       empty;
    logic       full;
    logic       stb_break;
    logic       push_req;
    logic       pop_req;
    logic       ctrl_wr;
    logic       clr;
    logic       do_pop;
    logic       do_push;
    logic [7:0] code;
    logic [7:0] head;
    logic [4:0] count_ext;
    logic       unused_po;

    // Address decode, FIFO flags and the folded code byte.
    always_comb begin
        pin_sel   = (pin_pa[7:2] == BASE[7:2]);
        offset    = pin_pa[1:0];
        empty     = (count_q == '0);
        full      = (count_q == CntW'(Depth));
        stb_break = ps2_stb && (ps2_data == BreakPrefix);
        push_req  = ps2_stb && (ps2_data != BreakPrefix);
        pop_req   = pin_pr && pin_sel && (offset == OffData);
        ctrl_wr   = pin_pw && pin_sel && (offset == OffStatus);
        clr       = ctrl_wr && pin_po[0];
        // Extended codes (Ex) already carry their own meaning in bit 7.
        code      = (ps2_code[7:4] == 4'hE) ? ps2_code : {brk_q, ps2_code[6:0]};
        // Pop on an empty FIFO is ignored; a push into a full FIFO is only
        // accepted when a pop frees a slot in the same cycle.
        do_pop    = pop_req && !empty && !clr;
        do_push   = push_req && (!full || do_pop) && !clr;
        head      = empty ? 8'h00 : mem_q[rd_ptr_q];
        count_ext = 5'(count_q);
        unused_po = ^pin_po[7:2];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // FIFO storage: write the folded code at the tail on an accepted push.
    always_comb begin
        for (int i = 0; i < int'(Depth); i++) begin
            mem_d[i] = mem_q[i];
        end
        if (do_push) begin
            mem_d[wr_ptr_q] = code;
        end
    end

    // Pointers, occupancy, flags and the event counter.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        brk_d    = brk_q;
        ovf_d    = ovf_q;
        ien_d    = ien_q;
        evcnt_d  = evcnt_q;

        // Every non-prefix strobe is an event, even when the byte is dropped.
        if (push_req) begin
            evcnt_d = evcnt_q + 8'd1;
        end

        if (ctrl_wr) begin
            ien_d = pin_po[1];
        end

        if (clr) begin
            // Clear beats a coincident push: no entry, no overflow.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            brk_d    = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            if (stb_break) begin
                brk_d = 1'b1;
            end else if (push_req) begin
                brk_d = 1'b0;
            end

            if (push_req && !do_push) begin
                ovf_d = 1'b1;
            end

            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end

            if (do_push && !do_pop) begin
                count_d = count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CntW'(1);
            end
        end

        intr_d = ien_q && !empty;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // FIFO storage flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Control and status flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            brk_q    <= 1'b0;
            ovf_q    <= 1'b0;
            ien_q    <= 1'b0;
            evcnt_q  <= 8'h00;
            intr_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            brk_q    <= brk_d;
            ovf_q    <= ovf_d;
            ien_q    <= ien_d;
            evcnt_q  <= evcnt_d;
            intr_q   <= intr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // Read mux; unmapped addresses float high like an empty bus.
    always_comb begin
        pin_pi = 8'hFF;
        if (pin_sel) begin
            case (offset)
                OffData:   pin_pi = head;
                OffStatus: pin_pi = {!empty, full, ovf_q, count_ext};
                OffEvcnt:  pin_pi = evcnt_q;
                OffFlags:  pin_pi = {6'b0, ien_q, brk_q};
                default:   pin_pi = 8'hFF;
            endcase
        end
    end

    assign pin_intr = intr_q;

endmodule
